// File: rtl/mru_ctrl.sv
// mru_ctrl: input-side controller for the MRU stack datapath.
// Synchronizes and debounces four push-buttons on a divided tick, converts
// presses into round-robin arbitrated push requests on a valid/ready handshake,
// and raises a one-cycle stack clear after a long four-button hold.
// Optional build macro: MRU_CTRL_DEDUP_EN (drop presses that repeat the most
// recently pushed button id instead of pushing a duplicate).
module mru_ctrl #(
    parameter int TICK_DIV   = 4,
    parameter int DEBOUNCE   = 3,
    parameter int CLEAR_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       b1,
    input  logic       b2,
    input  logic       b3,
    input  logic       b4,
    output logic       push_valid,
    output logic [2:0] push_id,
    input  logic       push_ready,
    output logic       clear,
    output logic       busy
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int HW = $clog2(CLEAR_HOLD + 1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_COOLDOWN} state_t;

    logic [3:0]    w_btn;
    logic [3:0]    r_sync1, r_sync2;
    logic [TW-1:0] r_tick_cnt;
    logic          w_tick;
    logic [3:0]    r_deb, r_deb_q, w_rise;
    logic [CW-1:0] r_cnt [4];
    logic [HW-1:0] r_hold_cnt;
    logic          r_armed, r_lock, w_arm, w_all_on, w_all_off;
    state_t        r_state, w_state_nxt;
    logic [3:0]    r_pending, w_pend_nxt;
    logic [1:0]    r_ptr, w_ptr_nxt, r_gnt_idx, w_gnt_nxt, w_win_idx;
    logic [2:0]    r_last_id, w_last_nxt, r_id, w_id_nxt, w_win_id;
    logic          r_valid, w_valid_nxt, w_win_any, w_dup, w_fire;
    logic          r_clear, r_busy;

    assign w_btn     = {b4, b3, b2, b1};
    assign w_tick    = (r_tick_cnt == TW'(TICK_DIV - 1));
    assign w_rise    = r_deb & ~r_deb_q;
    assign w_all_on  = (r_deb == 4'b1111);
    assign w_all_off = (r_deb == 4'b0000);
    assign w_arm     = w_all_on && (r_hold_cnt == HW'(CLEAR_HOLD)) && !r_lock;
    assign w_win_id  = {1'b0, w_win_idx} + 3'd1;

`ifdef MRU_CTRL_DEDUP_EN
    assign w_dup = (w_win_id == r_last_id);
`else
    assign w_dup = 1'b0;
`endif

    assign push_valid = r_valid;
    assign push_id    = r_id;
    assign clear      = r_clear;
    assign busy       = r_busy;

    // Two-flop button synchronizer and free-running sample tick divider.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_tick_cnt <= '0;
        end else begin
            r_sync1    <= w_btn;
            r_sync2    <= r_sync1;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
        end
    end

    // Per-button debouncer: level changes only after DEBOUNCE differing ticks.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_deb   <= '0;
            r_deb_q <= '0;
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            r_deb_q <= r_deb;
            if (w_tick) begin
                for (int i = 0; i < 4; i++) begin
                    if (r_sync2[i] == r_deb[i]) begin
                        r_cnt[i] <= '0;
                    end else if (r_cnt[i] == CW'(DEBOUNCE - 1)) begin
                        r_deb[i] <= r_sync2[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Long-hold detector; the lock blocks re-arming until all buttons are released.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hold_cnt <= '0;
            r_armed    <= 1'b0;
            r_lock     <= 1'b0;
        end else begin
            if (w_tick) begin
                if (!w_all_on)
                    r_hold_cnt <= '0;
                else if (r_hold_cnt != HW'(CLEAR_HOLD))
                    r_hold_cnt <= r_hold_cnt + 1'b1;
            end
            if (w_fire)
                r_armed <= 1'b0;
            else if (w_arm)
                r_armed <= 1'b1;
            if (w_arm)
                r_lock <= 1'b1;
            else if (w_all_off)
                r_lock <= 1'b0;
        end
    end

    // Round-robin search: lowest offset from ptr with a pending bit wins.
    always_comb begin
        w_win_any = 1'b0;
        w_win_idx = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (r_pending[r_ptr + 2'(k)]) begin
                w_win_any = 1'b1;
                w_win_idx = r_ptr + 2'(k);
            end
        end
    end

    // Next-state logic for the grant FSM, pending set and clear action.
    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pending;
        w_ptr_nxt   = r_ptr;
        w_last_nxt  = r_last_id;
        w_valid_nxt = r_valid;
        w_id_nxt    = r_id;
        w_gnt_nxt   = r_gnt_idx;
        w_fire      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_armed) begin
                    w_fire = 1'b1;
                end else if (w_win_any) begin
                    if (w_dup) begin
                        w_pend_nxt[w_win_idx] = 1'b0;
                    end else begin
                        w_state_nxt = S_GRANT;
                        w_valid_nxt = 1'b1;
                        w_id_nxt    = w_win_id;
                        w_gnt_nxt   = w_win_idx;
                    end
                end
            end
            S_GRANT: begin
                if (push_ready) begin
                    w_pend_nxt[r_gnt_idx] = 1'b0;
                    w_ptr_nxt   = r_gnt_idx + 2'd1;
                    w_last_nxt  = r_id;
                    w_valid_nxt = 1'b0;
                    w_id_nxt    = 3'd0;
                    w_state_nxt = S_COOLDOWN;
                end
            end
            S_COOLDOWN: begin
                if (r_armed)
                    w_fire = 1'b1;
                else if (w_tick)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_fire) begin
            w_pend_nxt  = 4'b0000;
            w_last_nxt  = 3'd0;
            w_ptr_nxt   = 2'd0;
            w_state_nxt = S_IDLE;
        end
        // A new press on the same edge as a clear of its bit is kept.
        w_pend_nxt = w_pend_nxt | w_rise;
    end

    // FSM, arbitration and output registers; busy tracks the next state/pending.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_ptr     <= '0;
            r_last_id <= '0;
            r_valid   <= 1'b0;
            r_id      <= '0;
            r_gnt_idx <= '0;
            r_clear   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pend_nxt;
            r_ptr     <= w_ptr_nxt;
            r_last_id <= w_last_nxt;
            r_valid   <= w_valid_nxt;
            r_id      <= w_id_nxt;
            r_gnt_idx <= w_gnt_nxt;
            r_clear   <= w_fire;
            r_busy    <= (w_state_nxt != S_IDLE) || (w_pend_nxt != 4'b0000);
        end
    end
endmodule
